branch_pc_unit: RTL

//  Fetch-PC register and control-flow resolver for the RV32I core. Consumes the
//  ALU's 6-bit CCR (EQ|NE|LT|GE|LTU|GEU) plus opcode/funct3 of the executing

---
 rtl/branch_pc_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/branch_pc_unit.sv
// Fetch-PC register and control-flow resolver: turns the ALU condition flags plus
// the executing opcode/funct3 into the next PC, a timed flush, or a misaligned-target trap.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        inst_valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [5:0]  ccr_flags,
  input  logic [31:0] rs1_data,
  input  logic [31:0] imm,
  input  logic        trap_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        taken,
  output logic        flush,
  output logic        trap,
  output logic [31:0] trap_pc
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Counter only needs to reach FLUSH_CYCLES-1; keep at least one bit.
  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

  // ccr_flags bit positions
  localparam int unsigned F_EQ  = 5;
  localparam int unsigned F_NE  = 4;
  localparam int unsigned F_LT  = 3;
  localparam int unsigned F_GE  = 2;
  localparam int unsigned F_LTU = 1;
  localparam int unsigned F_GEU = 0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

  state_e            state_q;
  logic [31:0]       pc_q;
  logic [31:0]       trap_pc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              taken_q;
  logic              flush_q;
  logic              trap_q;

  logic              is_branch;
  logic              is_jal;
  logic              is_jalr;
  logic              cond_true;
  logic [31:0]       branch_target;
  logic [31:0]       jalr_target;
  logic [31:0]       target;
  logic              redirect;
  logic              misaligned;

  assign pc_plus4 = pc_q + 32'd4;

  // NOTE: every signal gets a default at the top of always_comb so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    is_branch     = 1'b0;
    is_jal        = 1'b0;
    is_jalr       = 1'b0;
    cond_true     = 1'b0;
    branch_target = pc_q + imm;
    jalr_target   = (rs1_data + imm) & ~32'h1;

    case (opcode)
      OP_BRANCH: is_branch = 1'b1;
      OP_JAL:    is_jal    = 1'b1;
      OP_JALR:   is_jalr   = 1'b1;
      default:   ;
    endcase

    // funct3 010/011 are reserved and never taken.
    case (funct3)
      3'b000:  cond_true = ccr_flags[F_EQ];
      3'b001:  cond_true = ccr_flags[F_NE];
      3'b100:  cond_true = ccr_flags[F_LT];
      3'b101:  cond_true = ccr_flags[F_GE];
      3'b110:  cond_true = ccr_flags[F_LTU];
      3'b111:  cond_true = ccr_flags[F_GEU];
      default: cond_true = 1'b0;
    endcase

    target     = is_jalr ? jalr_target : branch_target;
    redirect   = is_jal | is_jalr | (is_branch & cond_true);
    misaligned = target[1];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      trap_pc_q <= 32'h0;
      cnt_q     <= '0;
      taken_q   <= 1'b0;
      flush_q   <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      // taken is a single-cycle pulse even when the pipeline is stalled.
      taken_q <= 1'b0;

      case (state_q)
        ST_RUN: begin
          if (!stall && inst_valid) begin
            if (redirect && misaligned) begin
              pc_q      <= TRAP_VECTOR;
              trap_pc_q <= pc_q;
              trap_q    <= 1'b1;
              state_q   <= ST_TRAP;
            end else if (redirect) begin
              pc_q    <= target;
              taken_q <= 1'b1;
              flush_q <= 1'b1;
              cnt_q   <= CNT_INIT;
              state_q <= ST_FLUSH;
            end else begin
              pc_q <= pc_plus4;
            end
          end
        end

        ST_FLUSH: begin
          if (!stall) begin
            if (cnt_q == '0) begin
              flush_q <= 1'b0;
              state_q <= ST_RUN;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end

        // The acknowledge is accepted even under stall so a trap cannot wedge.
        ST_TRAP: begin
          if (trap_ack) begin
            trap_q  <= 1'b0;
            state_q <= ST_RUN;
          end
        end

        default: begin
          flush_q <= 1'b0;
          trap_q  <= 1'b0;
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign pc      = pc_q;
  assign taken   = taken_q;
  assign flush   = flush_q;
  assign trap    = trap_q;
  assign trap_pc = trap_pc_q;

endmodule
